// File: rtl/vga_timing_gen_pkg.sv
// ============================================================================
// Module      : vga_timing_gen_pkg
// Description : 640x480@60 Hz timing constants shared by the timing generator,
//               sprite and ROM-address stages, plus small helper types.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package vga_timing_gen_pkg;

    // 640x480@60 Hz horizontal timing, in pixel ticks
    localparam int C_HPIXELS = 800;
    localparam int C_HSP     = 96;
    localparam int C_HBP     = 144;
    localparam int C_HFP     = 784;

    // 640x480@60 Hz vertical timing, in lines
    localparam int C_VLINES  = 521;
    localparam int C_VSP     = 2;
    localparam int C_VBP     = 31;
    localparam int C_VFP     = 511;

    localparam int C_CNT_W   = 10;
    localparam int C_FC_W    = 8;
    localparam int C_DIV_W   = 5;

    // Bits carried through the sync delay line
    typedef struct packed {
        logic hs;
        logic vs;
        logic vid;
    } sync_bits_t;

    // Idle level of the delay line: syncs deasserted (high), video off
    localparam sync_bits_t C_SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, vid: 1'b0};

    // True when lo <= v < hi
    function automatic logic in_window(input logic [C_CNT_W-1:0] v,
                                       input int lo, input int hi);
        return (v >= C_CNT_W'(lo)) && (v < C_CNT_W'(hi));
    endfunction

endpackage

`default_nettype wire

// File: rtl/vga_timing_gen_sync_delay.sv
// ============================================================================
// Module      : sync_delay
// Description : PIPE-deep shift register advanced by ce, with a per-bit
//               reset/clear value. PIPE=0 is a combinational pass-through.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module sync_delay #(
    parameter int               PIPE    = 1,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ce,
    input  logic             clr,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (PIPE == 0) begin : g_pass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] r_stage [PIPE];

            // Shift on each pixel tick; clear loads the idle value into every stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < PIPE; i++) r_stage[i] <= RST_VAL;
                end else if (clr) begin
                    for (int i = 0; i < PIPE; i++) r_stage[i] <= RST_VAL;
                end else if (ce) begin
                    r_stage[0] <= din;
                    for (int i = 1; i < PIPE; i++) r_stage[i] <= r_stage[i-1];
                end
            end

            assign dout = r_stage[PIPE-1];
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/vga_timing_gen.sv
// ============================================================================
// Module      : vga_timing_gen
// Description : VGA pixel-timing generator. Pixel-clock enable divider,
//               horizontal/vertical counters, active-video flag, delayed
//               sync outputs and frame bookkeeping pulses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vga_timing_gen
    import vga_timing_gen_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int HPIXELS = C_HPIXELS,
    parameter int VLINES  = C_VLINES,
    parameter int HSP     = C_HSP,
    parameter int VSP     = C_VSP,
    parameter int HBP     = C_HBP,
    parameter int HFP     = C_HFP,
    parameter int VBP     = C_VBP,
    parameter int VFP     = C_VFP,
    parameter int PIPE    = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    output logic              pix_ce,
    output logic [C_CNT_W-1:0] hc,
    output logic [C_CNT_W-1:0] vc,
    output logic              vidon,
    output logic              vidon_d,
    output logic              hsync,
    output logic              vsync,
    output logic              frame_start,
    output logic              vblank_irq,
    output logic [C_FC_W-1:0] frame_cnt
);

    localparam logic [C_DIV_W-1:0] C_DIV_LAST = C_DIV_W'(CLK_DIV - 1);
    localparam logic [C_CNT_W-1:0] C_H_LAST   = C_CNT_W'(HPIXELS - 1);
    localparam logic [C_CNT_W-1:0] C_V_LAST   = C_CNT_W'(VLINES - 1);
    localparam logic [C_CNT_W-1:0] C_V_PREVFP = C_CNT_W'(VFP - 1);

    logic [C_DIV_W-1:0] r_div;
    logic [C_CNT_W-1:0] r_hc;
    logic [C_CNT_W-1:0] r_vc;
    logic [C_FC_W-1:0]  r_frame_cnt;
    logic               r_frame_start;
    logic               r_vblank_irq;

    logic       w_pix_ce;
    logic       w_line_end;
    logic       w_frame_end;
    logic       w_to_vfp;
    logic       w_vidon;
    sync_bits_t w_raw;
    sync_bits_t w_dly;

    assign w_pix_ce    = (r_div == C_DIV_LAST) && en;
    assign w_line_end  = (r_hc == C_H_LAST);
    assign w_frame_end = w_line_end && (r_vc == C_V_LAST);
    assign w_to_vfp    = w_line_end && (r_vc == C_V_PREVFP);

    // Pixel-clock divider; held at zero while scanning is disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div <= '0;
        end else if (!en || (r_div == C_DIV_LAST)) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Horizontal/vertical scan counters and completed-frame counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hc        <= '0;
            r_vc        <= '0;
            r_frame_cnt <= '0;
        end else if (!en) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_pix_ce) begin
            if (w_line_end) begin
                r_hc <= '0;
                if (w_frame_end) begin
                    r_vc        <= '0;
                    r_frame_cnt <= r_frame_cnt + 1'b1;
                end else begin
                    r_vc <= r_vc + 1'b1;
                end
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    // Single-clk pulses following the frame-wrap and vc=VFP ticks
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_start <= 1'b0;
            r_vblank_irq  <= 1'b0;
        end else begin
            r_frame_start <= w_pix_ce && w_frame_end;
            r_vblank_irq  <= w_pix_ce && w_to_vfp;
        end
    end

    // Undelayed active-video flag and raw (active-low) sync levels
    always_comb begin
        w_vidon    = in_window(r_hc, HBP, HFP) && in_window(r_vc, VBP, VFP);
        w_raw.hs   = (r_hc >= C_CNT_W'(HSP));
        w_raw.vs   = (r_vc >= C_CNT_W'(VSP));
        w_raw.vid  = w_vidon;
    end

    sync_delay #(
        .PIPE    (PIPE),
        .WIDTH   (3),
        .RST_VAL (C_SYNC_IDLE)
    ) u_sync_delay (
        .clk   (clk),
        .rst_n (rst_n),
        .ce    (w_pix_ce),
        .clr   (!en),
        .din   (w_raw),
        .dout  (w_dly)
    );

    assign pix_ce      = w_pix_ce;
    assign hc          = r_hc;
    assign vc          = r_vc;
    assign vidon       = w_vidon;
    assign vidon_d     = w_dly.vid;
    assign hsync       = w_dly.hs;
    assign vsync       = w_dly.vs;
    assign frame_start = r_frame_start;
    assign vblank_irq  = r_vblank_irq;
    assign frame_cnt   = r_frame_cnt;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
// ============================================================================
// Module      : tb_vga_timing_gen
// Description : Self-checking bench for vga_timing_gen using a reduced
//               timing (12 x 8 pixels, CLK_DIV=2, PIPE=2) so whole frames
//               and the frame-counter wrap fit in a short run.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_vga_timing_gen;

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       pix_ce;
    logic [9:0] hc;
    logic [9:0] vc;
    logic       vidon;
    logic       vidon_d;
    logic       hsync;
    logic       vsync;
    logic       frame_start;
    logic       vblank_irq;
    logic [7:0] frame_cnt;

    int n_checks = 0;
    int n_errors = 0;
    int k        = 0;

    vga_timing_gen #(
        .CLK_DIV (2),
        .HPIXELS (12),
        .VLINES  (8),
        .HSP     (2),
        .VSP     (2),
        .HBP     (3),
        .HFP     (10),
        .VBP     (2),
        .VFP     (6),
        .PIPE    (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .pix_ce      (pix_ce),
        .hc          (hc),
        .vc          (vc),
        .vidon       (vidon),
        .vidon_d     (vidon_d),
        .hsync       (hsync),
        .vsync       (vsync),
        .frame_start (frame_start),
        .vblank_irq  (vblank_irq),
        .frame_cnt   (frame_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         k;
        logic [9:0] hc;
        logic [9:0] vc;
        logic       pce;
        logic       vid;
        logic       hs;
        logic       vs;
        logic       vidd;
        logic       fs;
        logic       vb;
        logic [7:0] fc;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s @k=%0d: got %0d expected %0d", name, k, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input vec_t e);
        chk({tag, ".hc"},          int'(hc),          int'(e.hc));
        chk({tag, ".vc"},          int'(vc),          int'(e.vc));
        chk({tag, ".pix_ce"},      int'(pix_ce),      int'(e.pce));
        chk({tag, ".vidon"},       int'(vidon),       int'(e.vid));
        chk({tag, ".hsync"},       int'(hsync),       int'(e.hs));
        chk({tag, ".vsync"},       int'(vsync),       int'(e.vs));
        chk({tag, ".vidon_d"},     int'(vidon_d),     int'(e.vidd));
        chk({tag, ".frame_start"}, int'(frame_start), int'(e.fs));
        chk({tag, ".vblank_irq"},  int'(vblank_irq),  int'(e.vb));
        chk({tag, ".frame_cnt"},   int'(frame_cnt),   int'(e.fc));
    endtask

    // One clock edge, sampled 1 time unit after it
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            k++;
        end
    endtask

    initial begin
        vec_t e;

        //           k    hc  vc  pce vid hs vs vdd fs vb fc
        tbl.push_back('{  0,  0, 0, 0, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{  1,  0, 0, 1, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{  2,  1, 0, 0, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{  4,  2, 0, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{  8,  4, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{ 22, 11, 0, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{ 24,  0, 1, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{ 26,  1, 1, 0, 0, 1, 0, 0, 0, 0, 0});
        tbl.push_back('{ 28,  2, 1, 0, 0, 0, 0, 0, 0, 0, 0});
        tbl.push_back('{ 54,  3, 2, 0, 1, 0, 1, 0, 0, 0, 0});
        tbl.push_back('{ 58,  5, 2, 0, 1, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{ 66,  9, 2, 0, 1, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{ 68, 10, 2, 0, 0, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{ 72,  0, 3, 0, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{138,  9, 5, 0, 1, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{140, 10, 5, 0, 0, 1, 1, 1, 0, 0, 0});
        tbl.push_back('{144,  0, 6, 0, 0, 1, 1, 0, 0, 1, 0});
        tbl.push_back('{145,  0, 6, 1, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{190, 11, 7, 0, 0, 1, 1, 0, 0, 0, 0});
        tbl.push_back('{192,  0, 0, 0, 0, 1, 1, 0, 1, 0, 1});
        tbl.push_back('{193,  0, 0, 1, 0, 1, 1, 0, 0, 0, 1});
        tbl.push_back('{196,  2, 0, 0, 0, 0, 0, 0, 0, 0, 1});

        // Hold reset for a few clocks and check the reset state
        rst_n = 1'b0;
        en    = 1'b1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk_all("reset", '{0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});

        // Release away from the edge; k counts edges since release
        rst_n = 1'b1;
        k     = 0;
        foreach (tbl[i]) begin
            if (tbl[i].k > k) step(tbl[i].k - k);
            chk_all("vec", tbl[i]);
        end

        // Drop en mid-line with vidon_d high: synchronous clear, frame_cnt holds
        step(260 - k);
        chk("pre_en.hc",      int'(hc),      10);
        chk("pre_en.vc",      int'(vc),      2);
        chk("pre_en.vidon_d", int'(vidon_d), 1);
        en = 1'b0;
        step(1);
        chk_all("en_low", '{0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd1});
        step(3);
        chk("en_low.pix_ce", int'(pix_ce), 0);
        chk("en_low.hc",     int'(hc),     0);

        // Restart: first pix_ce one edge later, hc advances on the next
        en = 1'b1;
        k  = 0;
        step(1);
        chk("restart.pix_ce", int'(pix_ce), 1);
        chk("restart.hc0",    int'(hc),     0);
        step(1);
        chk("restart.hc1",    int'(hc),     1);

        // Run 255 frames from restart: frame_cnt 1 -> 255 -> wraps to 0
        step(254 * 192 - k);
        chk("fc255", int'(frame_cnt), 255);
        chk("fc255.frame_start", int'(frame_start), 1);
        step(255 * 192 - k);
        chk_all("fc_wrap", '{0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'd0});

        // Mid-frame asynchronous reset: hc=1 vc=2, vsync currently low
        step(50);
        chk("pre_rst.hc",    int'(hc),    1);
        chk("pre_rst.vc",    int'(vc),    2);
        chk("pre_rst.vsync", int'(vsync), 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all("async_rst", '{0, 10'd0, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0});

        // Release: no pulse, scanning resumes from zero
        @(posedge clk); #1;
        rst_n = 1'b1;
        k     = 0;
        step(4);
        chk_all("post_rst", '{0, 10'd2, 10'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0});

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
